// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions for the program loader: FSM state encoding and
// the byte / instruction / address widths used by the loader and its assembler.
package program_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 18;
    localparam int ADDR_W  = 16;

    typedef enum logic [2:0] {
        COUNT_HI,
        COUNT_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loaderState_t;

endpackage

// File: rtl/program_loader_instr_assembler.sv
// Packs payload byte triples into 18-bit instruction words and emits a
// one-cycle registered word strobe after the third byte of each triple.
module instr_assembler
    import program_loader_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [0:BYTE_W-1]  i_byte,
    input  logic               i_take,
    output logic               o_lastSlot,
    output logic [0:INSTR_W-1] o_word,
    output logic               o_wordValid
);

    logic [1:0]        slot;
    logic [0:1]        hiBits;
    logic [0:BYTE_W-1] midByte;

    assign o_lastSlot = (slot == 2'd2);

    // Partial triples are discarded by reset: slot returns to 0 and no strobe fires.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            slot        <= 2'd0;
            hiBits      <= '0;
            midByte     <= '0;
            o_word      <= '0;
            o_wordValid <= 1'b0;
        end else begin
            o_wordValid <= 1'b0;
            if (i_take) begin
                case (slot)
                    2'd0: begin
                        hiBits <= i_byte[6:7];
                        slot   <= 2'd1;
                    end
                    2'd1: begin
                        midByte <= i_byte;
                        slot    <= 2'd2;
                    end
                    default: begin
                        o_word      <= {hiBits, midByte, i_byte};
                        o_wordValid <= 1'b1;
                        slot        <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: parses a counted, checksummed byte stream into
// 18-bit program memory writes and holds the CPU until a good load completes.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS = 65535
)
(
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [0:BYTE_W-1]  i_byte,
    input  logic               i_byteValid,
    output logic               o_byteReady,
    output logic [0:ADDR_W-1]  o_memAddr,
    output logic [0:INSTR_W-1] o_memData,
    output logic               o_memWrite,
    output logic               o_cpuHalt,
    output logic               o_done,
    output logic               o_error
);

    loaderState_t      state, nextState;
    logic [0:BYTE_W-1] countHi, checksum;
    logic [0:ADDR_W-1] wordTotal, wordCount, countWord;
    logic              transfer, assembleTake, lastSlot, lastWord, countBad;
    logic              readyNext, haltNext, doneNext, errorNext;

    assign transfer     = i_byteValid && o_byteReady;
    assign assembleTake = transfer && (state == DATA);
    assign countWord    = {countHi, i_byte};
    assign countBad     = (countWord == '0) || (32'(countWord) > 32'(MAX_WORDS));
    assign lastWord     = (wordCount == wordTotal - 16'd1);

    instr_assembler u_assembler (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_byte      (i_byte),
        .i_take      (assembleTake),
        .o_lastSlot  (lastSlot),
        .o_word      (o_memData),
        .o_wordValid (o_memWrite)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            countHi   <= '0;
            checksum  <= '0;
            wordTotal <= '0;
            wordCount <= '0;
            o_memAddr <= '0;
        end else begin
            if (transfer && state == COUNT_HI) countHi <= i_byte;
            if (transfer && state == COUNT_LO) wordTotal <= countWord;
            if (transfer && (state inside {COUNT_HI, COUNT_LO, DATA}))
                checksum <= checksum ^ i_byte;
            if (assembleTake && lastSlot) wordCount <= wordCount + 16'd1;
            if (o_memWrite) o_memAddr <= o_memAddr + 16'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state       <= COUNT_HI;
            o_byteReady <= 1'b0;
            o_cpuHalt   <= 1'b1;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= nextState;
            o_byteReady <= readyNext;
            o_cpuHalt   <= haltNext;
            o_done      <= doneNext;
            o_error     <= errorNext;
        end
    end

    // CHECK is entered on the last payload byte so a checksum byte arriving
    // during the final write cycle is still consumed at full throughput.
    always_comb begin
        nextState = state;
        case (state)
            COUNT_HI: if (transfer) nextState = COUNT_LO;
            COUNT_LO: if (transfer) nextState = countBad ? ERROR : DATA;
            DATA:     if (assembleTake && lastSlot && lastWord) nextState = CHECK;
            CHECK:    if (transfer) nextState = (i_byte == checksum) ? DONE : ERROR;
            default:  nextState = state;
        endcase
    end

    always_comb begin
        readyNext = !(nextState inside {DONE, ERROR});
        haltNext  = (nextState != DONE);
        doneNext  = (nextState == DONE);
        errorNext = (nextState == ERROR);
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected memory writes,
// an independent monitor pops and compares them as the DUT strobes o_memWrite.
module tb_program_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [17:0] data;
    } memWr_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic [0:7]  dutByte;
    logic        byteValid;
    logic        byteReady;
    logic [0:15] memAddr;
    logic [0:17] memData;
    logic        memWrite;
    logic        cpuHalt;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    memWr_t      expQ[$];
    int          writeCycles[$];
    logic [7:0]  stream[$];
    logic        prevWrite = 1'b0;

    program_loader #(.MAX_WORDS(4)) dut (
        .i_clock     (clk),
        .i_reset_n   (resetN),
        .i_byte      (dutByte),
        .i_byteValid (byteValid),
        .o_byteReady (byteReady),
        .o_memAddr   (memAddr),
        .o_memData   (memData),
        .o_memWrite  (memWrite),
        .o_cpuHalt   (cpuHalt),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (memWrite === 1'b1) begin
            writeCycles.push_back(cyc);
            checks++;
            if (prevWrite) begin
                errors++;
                $display("FAIL back_to_back_write: write high on consecutive cycles at cycle %0d", cyc);
            end
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", memAddr, memData);
            end else begin
                memWr_t e;
                e = expQ.pop_front();
                if (memAddr !== e.addr || memData !== e.data) begin
                    errors++;
                    $display("FAIL write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             memAddr, memData, e.addr, e.data);
                end
            end
        end
        prevWrite = (memWrite === 1'b1);
    end

    task automatic expectWrite(input logic [15:0] a, input logic [17:0] d);
        memWr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        logic rdy;
        int   waitCnt;
        if (gap > 0) begin
            byteValid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        dutByte   = b;
        byteValid = 1'b1;
        waitCnt   = 0;
        forever begin
            rdy = byteReady;
            @(posedge clk);
            #1;
            if (rdy) break;
            waitCnt++;
            if (waitCnt > 20) begin
                checks++;
                errors++;
                $display("FAIL byte_wait: ready 0 for %0d cycles, expected 1", waitCnt);
                break;
            end
        end
    endtask

    task automatic sendStream(input int maxGap);
        foreach (stream[i]) sendByte(stream[i], (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0);
        byteValid = 1'b0;
    endtask

    task automatic doReset(input bit checkState);
        resetN    = 1'b0;
        byteValid = 1'b0;
        dutByte   = 8'h00;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        if (checkState) begin
            chk("rst_ready", byteReady, 0);
            chk("rst_halt", cpuHalt, 1);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_addr", memAddr, 0);
            chk("rst_data", memData, 0);
            chk("rst_write", memWrite, 0);
        end
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", byteReady, 1);
    endtask

    task automatic loadThreeWords();
        stream = '{8'h00, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD,
                   8'hFC, 8'h00, 8'h01, 8'h43};
        expectWrite(16'd0, 18'h31234);
        expectWrite(16'd1, 18'h2ABCD);
        expectWrite(16'd2, 18'h00001);
    endtask

    initial begin
        resetN    = 1'b0;
        byteValid = 1'b0;
        dutByte   = 8'h00;

        // Single word, good checksum (00^01^03^A5^5A = FD).
        doReset(1);
        expectWrite(16'd0, 18'h3A55A);
        stream = '{8'h00, 8'h01, 8'h03, 8'hA5, 8'h5A, 8'hFD};
        sendStream(0);
        chk("single_done", done, 1);
        chk("single_error", error, 0);
        chk("single_halt", cpuHalt, 0);
        chk("single_ready", byteReady, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done_hold", done, 1);
        chk("single_pending", expQ.size(), 0);

        // Bad checksum: the word is still written, then ERROR.
        doReset(0);
        expectWrite(16'd0, 18'h3A55A);
        stream = '{8'h00, 8'h01, 8'h03, 8'hA5, 8'h5A, 8'hF8};
        sendStream(0);
        chk("badsum_error", error, 1);
        chk("badsum_done", done, 0);
        chk("badsum_halt", cpuHalt, 1);
        chk("badsum_ready", byteReady, 0);
        chk("badsum_pending", expQ.size(), 0);

        // Zero count.
        doReset(0);
        stream = '{8'h00, 8'h00};
        sendStream(0);
        chk("zero_error", error, 1);
        chk("zero_ready", byteReady, 0);

        // Oversize count with MAX_WORDS=4.
        doReset(0);
        stream = '{8'h00, 8'h05};
        sendStream(0);
        chk("over_error", error, 1);
        chk("over_halt", cpuHalt, 1);

        // Count equal to MAX_WORDS is accepted.
        doReset(0);
        stream = '{8'h00, 8'h04};
        sendStream(0);
        chk("max_error", error, 0);
        chk("max_ready", byteReady, 1);

        // Back-to-back throughput, N=3.
        doReset(0);
        writeCycles.delete();
        loadThreeWords();
        sendStream(0);
        chk("b2b_done", done, 1);
        chk("b2b_nwrites", writeCycles.size(), 3);
        if (writeCycles.size() == 3) begin
            chk("b2b_gap01", writeCycles[1] - writeCycles[0], 3);
            chk("b2b_gap12", writeCycles[2] - writeCycles[1], 3);
        end
        chk("b2b_pending", expQ.size(), 0);

        // Reset after two bytes of word 1, then a full reload.
        doReset(0);
        stream = '{8'h00, 8'h01, 8'h03, 8'hA5};
        sendStream(0);
        repeat (2) @(posedge clk);
        #1;
        doReset(0);
        chk("midrst_addr", memAddr, 0);
        expectWrite(16'd0, 18'h3A55A);
        stream = '{8'h00, 8'h01, 8'h03, 8'hA5, 8'h5A, 8'hFD};
        sendStream(0);
        chk("midrst_done", done, 1);
        chk("midrst_pending", expQ.size(), 0);

        // Random valid gaps, same data as the gap-free run.
        doReset(0);
        loadThreeWords();
        sendStream(3);
        chk("gaps_done", done, 1);
        chk("gaps_error", error, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("gaps_pending", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
